branch_target_buffer: RTL and testbench

- Responder side of the fetch-stage BTB lookup: takes the fetch PC and returns hit plus predicted next PC in the same cycle.
- Trained by resolved branches from the execute stage through an update port.
- Direct-mapped, register-based table. Each entry holds valid, tag, target and a 2-bit direction counter.
- Sits beside the fetch stage; the fetch stage selects the predicted PC on hit.

---
 rtl/branch_target_buffer_pkg.sv | 27 ++
 rtl/branch_target_buffer_if.sv | 18 +
 rtl/branch_target_buffer_sat_counter.sv | 25 ++
 rtl/branch_target_buffer.sv | 112 +++++++++++
 tb/tb_branch_target_buffer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types for the branch target buffer.
// Holds the PC type and the BTB geometry, entry layout and counter constants.
// Optional feature macro used elsewhere: BTB_DIRECTION_COUNTER_EN.
package branch_target_buffer_pkg;
    // Pipeline-wide PC type
    localparam int BTB_PC_WIDTH = 32;
    typedef logic [BTB_PC_WIDTH-1:0] PC;

    // BTB geometry (default build)
    localparam int BTB_ENTRY_NUM   = 16;
    localparam int BTB_INDEX_WIDTH = $clog2(BTB_ENTRY_NUM);
    localparam int BTB_TAG_WIDTH   = BTB_PC_WIDTH - BTB_INDEX_WIDTH - 2;

    typedef logic [BTB_INDEX_WIDTH-1:0] BtbIndex;
    typedef logic [BTB_TAG_WIDTH-1:0]   BtbTag;

    typedef struct packed {
        logic       valid;
        BtbTag      tag;
        PC          target;
        logic [1:0] counter;
    } BtbEntry;

    // Freshly allocated entries start weakly taken; reset leaves them weakly not-taken
    localparam logic [1:0] BTB_COUNTER_INIT  = 2'b10;
    localparam logic [1:0] BTB_COUNTER_RESET = 2'b01;
endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-side lookup interface of the branch target buffer.
// Ports:
//   pc             - fetch PC (driven by fetch)
//   btbHit         - predicted-taken hit (driven by BTB)
//   btbPredictedPc - predicted target, 0 when no hit (driven by BTB)
// Modports: master = fetch stage, slave = BTB.
interface branch_target_buffer_if
    import branch_target_buffer_pkg::*;
#(
    parameter int PC_WIDTH = BTB_PC_WIDTH
);
    logic [PC_WIDTH-1:0] pc;
    logic                btbHit;
    logic [PC_WIDTH-1:0] btbPredictedPc;

    modport master (output pc, input btbHit, input btbPredictedPc);
    modport slave  (input pc, output btbHit, output btbPredictedPc);
endinterface

// File: rtl/branch_target_buffer_sat_counter.sv
// btb_sat_counter: combinational 2-bit saturating next-state function.
// Ports:
//   cur - current counter value
//   inc - request increment (saturates at 2'b11)
//   dec - request decrement (saturates at 2'b00)
//   nxt - next counter value; inc and dec together leave it unchanged
// Only built when BTB_DIRECTION_COUNTER_EN is defined.
`ifdef BTB_DIRECTION_COUNTER_EN
module btb_sat_counter
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       inc,
    input  logic       dec,
    output logic [1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (inc && !dec && cur != 2'b11)
            nxt = cur + 2'd1;
        else if (dec && !inc && cur != 2'b00)
            nxt = cur - 2'd1;
    end
endmodule
`endif

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped, register-based BTB.
// Fetch looks up pc combinationally through the interface; execute trains the
// table with resolved branches over plain update wires.
// Ports:
//   clk, rst (sync, active-low)
//   fetch     - branch_target_buffer_if.slave (pc in, btbHit/btbPredictedPc out)
//   updValid, updPc, updTarget, updTaken - resolved-branch update
//   flush     - invalidate all entries
// Macro BTB_DIRECTION_COUNTER_EN: when defined each entry carries a 2-bit
// direction counter and only counter[1]=1 entries hit; otherwise a valid tag
// match hits and a not-taken match evicts the entry.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int ENTRY_NUM = BTB_ENTRY_NUM,
    parameter int PC_WIDTH  = BTB_PC_WIDTH
)(
    input  logic                clk,
    input  logic                rst,
    branch_target_buffer_if.slave fetch,
    input  logic                updValid,
    input  logic [PC_WIDTH-1:0] updPc,
    input  logic [PC_WIDTH-1:0] updTarget,
    input  logic                updTaken,
    input  logic                flush
);
    localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
    localparam int TAG_WIDTH   = PC_WIDTH - INDEX_WIDTH - 2;

    logic [ENTRY_NUM-1:0]                validArr;
    logic [ENTRY_NUM-1:0][TAG_WIDTH-1:0] tagArr;
    logic [ENTRY_NUM-1:0][PC_WIDTH-1:0]  targetArr;
`ifdef BTB_DIRECTION_COUNTER_EN
    logic [ENTRY_NUM-1:0][1:0]           cntArr;
    logic [1:0]                          cntNext;
`endif

    // Byte offset bits never take part in indexing or tagging
    logic [3:0] unusedPcBits;
    assign unusedPcBits = {fetch.pc[1:0], updPc[1:0]};

    // Lookup path, straight off the registered table (no write bypass)
    logic [INDEX_WIDTH-1:0] lkIdx;
    logic [TAG_WIDTH-1:0]   lkTag;
    logic                   lkMatch;
    logic                   lkHit;

    assign lkIdx   = fetch.pc[INDEX_WIDTH+1:2];
    assign lkTag   = fetch.pc[PC_WIDTH-1:INDEX_WIDTH+2];
    assign lkMatch = validArr[lkIdx] && (tagArr[lkIdx] == lkTag);
`ifdef BTB_DIRECTION_COUNTER_EN
    assign lkHit   = lkMatch && cntArr[lkIdx][1];
`else
    assign lkHit   = lkMatch;
`endif

    // Outputs are forced low while reset is held, not just after the edge
    assign fetch.btbHit         = rst && lkHit;
    assign fetch.btbPredictedPc = fetch.btbHit ? targetArr[lkIdx] : '0;

    // Update path
    logic [INDEX_WIDTH-1:0] uIdx;
    logic [TAG_WIDTH-1:0]   uTag;
    logic                   uMatch;

    assign uIdx   = updPc[INDEX_WIDTH+1:2];
    assign uTag   = updPc[PC_WIDTH-1:INDEX_WIDTH+2];
    assign uMatch = validArr[uIdx] && (tagArr[uIdx] == uTag);

`ifdef BTB_DIRECTION_COUNTER_EN
    btb_sat_counter uCnt (
        .cur (cntArr[uIdx]),
        .inc (updTaken),
        .dec (!updTaken),
        .nxt (cntNext)
    );
`endif

    // Priority: reset > flush > update
    always_ff @(posedge clk) begin
        if (!rst) begin
            validArr <= '0;
`ifdef BTB_DIRECTION_COUNTER_EN
            for (int i = 0; i < ENTRY_NUM; i++)
                cntArr[i] <= BTB_COUNTER_RESET;
`endif
        end else if (flush) begin
            validArr <= '0;
        end else if (updValid) begin
            if (updTaken) begin
                targetArr[uIdx] <= updTarget;
                if (uMatch) begin
`ifdef BTB_DIRECTION_COUNTER_EN
                    cntArr[uIdx] <= cntNext;
`endif
                end else begin
                    validArr[uIdx] <= 1'b1;
                    tagArr[uIdx]   <= uTag;
`ifdef BTB_DIRECTION_COUNTER_EN
                    cntArr[uIdx]   <= BTB_COUNTER_INIT;
`endif
                end
            end else if (uMatch) begin
`ifdef BTB_DIRECTION_COUNTER_EN
                cntArr[uIdx] <= cntNext;
`else
                validArr[uIdx] <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboarded bench for branch_target_buffer: the stimulus side predicts each
// cycle's lookup from a plain reference table and queues it; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_branch_target_buffer;
    localparam int N  = 16;
    localparam int IW = 4;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          updValid = 1'b0;
    logic          updTaken = 1'b0;
    logic          flush = 1'b0;
    logic [PW-1:0] updPc = '0;
    logic [PW-1:0] updTarget = '0;

    branch_target_buffer_if #(.PC_WIDTH(PW)) fif ();

    branch_target_buffer #(.ENTRY_NUM(N), .PC_WIDTH(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .fetch     (fif.slave),
        .updValid  (updValid),
        .updPc     (updPc),
        .updTarget (updTarget),
        .updTaken  (updTaken),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          hit;
        logic [PW-1:0] pred;
        logic [PW-1:0] pc;
    } ExpT;

    ExpT expQ[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference table: one slot per index, strength as an integer 0..3
    bit          mValid [N];
    logic [31:0] mTag   [N];
    logic [31:0] mTarget[N];
    int          mStr   [N];

    function automatic int idxOf(input logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic logic [31:0] tagOf(input logic [31:0] a);
        return a >> (IW + 2);
    endfunction

    function automatic bit modelMatch(input logic [31:0] a);
        return mValid[idxOf(a)] && (mTag[idxOf(a)] == tagOf(a));
    endfunction

    function automatic bit modelPredTaken(input logic [31:0] a);
`ifdef BTB_DIRECTION_COUNTER_EN
        return modelMatch(a) && (mStr[idxOf(a)] >= 2);
`else
        return modelMatch(a);
`endif
    endfunction

    task automatic modelUpdate(input logic r, input logic uv, input logic [31:0] up,
                               input logic [31:0] ut, input logic tk, input logic fl);
        int i;
        i = idxOf(up);
        if (!r) begin
            for (int k = 0; k < N; k++) begin
                mValid[k] = 1'b0;
                mStr[k]   = 1;
            end
        end else if (fl) begin
            for (int k = 0; k < N; k++) mValid[k] = 1'b0;
        end else if (uv) begin
            if (tk) begin
                if (modelMatch(up)) begin
                    mTarget[i] = ut;
                    mStr[i]    = (mStr[i] < 3) ? mStr[i] + 1 : 3;
                end else begin
                    mValid[i]  = 1'b1;
                    mTag[i]    = tagOf(up);
                    mTarget[i] = ut;
                    mStr[i]    = 2;
                end
            end else if (modelMatch(up)) begin
`ifdef BTB_DIRECTION_COUNTER_EN
                mStr[i] = (mStr[i] > 0) ? mStr[i] - 1 : 0;
`else
                mValid[i] = 1'b0;
`endif
            end
        end
    endtask

    // One clock of stimulus; expected lookup reflects pre-edge table contents
    task automatic step(input logic r, input logic [31:0] p, input logic uv,
                        input logic [31:0] up, input logic [31:0] ut,
                        input logic tk, input logic fl);
        ExpT e;
        rst = r; fif.pc = p; updValid = uv; updPc = up;
        updTarget = ut; updTaken = tk; flush = fl;
        e.pc   = p;
        e.hit  = r && modelPredTaken(p);
        e.pred = e.hit ? mTarget[idxOf(p)] : '0;
        expQ.push_back(e);
        @(posedge clk);
        modelUpdate(r, uv, up, ut, tk, fl);
        #1;
    endtask

    task automatic look(input logic [31:0] p);
        step(1'b1, p, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] p, input logic [31:0] up,
                       input logic [31:0] ut, input logic tk);
        step(1'b1, p, 1'b1, up, ut, tk, 1'b0);
    endtask

    // Monitor: lookup outputs are always presented, so compare every cycle
    // that has a queued expectation
    initial begin
        ExpT e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                vectors++;
                if (fif.btbHit !== e.hit || fif.btbPredictedPc !== e.pred) begin
                    miscompares++;
                    $display("FAIL lookup pc=%h: got hit=%b tgt=%h, want hit=%b tgt=%h",
                             e.pc, fif.btbHit, fif.btbPredictedPc, e.hit, e.pred);
                end
            end
        end
    end

    initial begin
        logic [31:0] p, up, ut;
        for (int k = 0; k < N; k++) begin
            mValid[k] = 1'b0; mTag[k] = '0; mTarget[k] = '0; mStr[k] = 1;
        end
        @(posedge clk); #1;

        // Reset held two cycles, then a cold lookup
        step(1'b0, 32'h1040, 1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 32'h1040, 1'b0, '0, '0, 1'b0, 1'b0);
        look(32'h1040);

        // Allocate; same-cycle lookup still misses
        upd(32'h1040, 32'h1040, 32'h2000, 1'b1);
        look(32'h1040);
        look(32'h1044);

        // Direction training
        upd(32'h1040, 32'h1040, 32'h0, 1'b0);
        look(32'h1040);
        upd(32'h1040, 32'h1040, 32'h0, 1'b0);
        look(32'h1040);
        upd(32'h1040, 32'h1040, 32'h2000, 1'b1);
        look(32'h1040);

        // Alias / replace at index 0
        upd(32'h1040, 32'h1040, 32'h2000, 1'b1);
        upd(32'h2040, 32'h2040, 32'h3000, 1'b1);
        look(32'h1040);
        look(32'h2040);

        // Same-cycle lookup and retarget
        upd(32'h1040, 32'h1040, 32'h2000, 1'b1);
        upd(32'h1040, 32'h1040, 32'h4000, 1'b1);
        look(32'h1040);

        // Flush beats a simultaneous update
        upd(32'h3040, 32'h3040, 32'h7000, 1'b1);
        step(1'b1, 32'h1040, 1'b1, 32'h3040, 32'h5000, 1'b1, 1'b1);
        look(32'h1040);
        look(32'h3040);

        // Reset beats a simultaneous update; outputs forced low during reset
        upd(32'h1040, 32'h1040, 32'h2000, 1'b1);
        step(1'b0, 32'h1040, 1'b1, 32'h1040, 32'h6000, 1'b1, 1'b0);
        step(1'b0, 32'h1040, 1'b0, '0, '0, 1'b0, 1'b0);
        look(32'h1040);

        // Randomized traffic over a small tag pool so entries collide and hit
        for (int n = 0; n < 500; n++) begin
            p  = ($urandom_range(1, 3) << (IW + 2)) | ($urandom_range(0, N - 1) << 2)
                 | $urandom_range(0, 3);
            up = ($urandom_range(1, 3) << (IW + 2)) | ($urandom_range(0, N - 1) << 2)
                 | $urandom_range(0, 3);
            ut = $urandom;
            step(($urandom_range(0, 59) != 0), p, ($urandom_range(0, 1) == 1), up, ut,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        // Let the monitor drain, bounded
        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", expQ.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
